mips_mem_responder: RTL and testbench

- Memory-side responder for the pipelined MIPS core's instruction and data ports.
- Serves instruction fetch from an internal instruction RAM, and data loads/stores from a data RAM plus a small MMIO window: cycle counter, halt/tohost register, scratch register.
- Sits beside the core at SoC top level and drives instr/readdata back to it.
- Includes a side-band loader port to fill instruction RAM before or while the core runs.

---
 rtl/mips_mem_pkg.sv | 29 ++
 rtl/mips_mem_responder_ram.sv | 25 ++
 rtl/mips_mem_responder.sv | 145 ++++++++++++++
 tb/tb_mips_mem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared constants and address-decode helpers for the MIPS memory responder.
package mips_mem_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_MASK         = 32'hFFFF_0000;

  localparam logic [15:0] OFF_CYCLE   = 16'h0000;
  localparam logic [15:0] OFF_TOHOST  = 16'h0004;
  localparam logic [15:0] OFF_SCRATCH = 16'h0008;

  typedef enum logic [1:0] {
    REG_DMEM = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // Data RAM wins over the MMIO window should the two ever overlap.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] dmem_bytes,
                                            input logic [31:0] mmio_base);
    if (addr < dmem_bytes) begin
      return REG_DMEM;
    end else if ((addr & MMIO_MASK) == (mmio_base & MMIO_MASK)) begin
      return REG_MMIO;
    end
    return REG_NONE;
  endfunction

endpackage

// File: rtl/mips_mem_responder_ram.sv
// Single-write, single-read word RAM: synchronous write, combinational read, no reset.
module ram_1w1r_async #(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read returns the pre-edge word during a same-address write.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_mem_responder.sv
// Instruction/data memory responder for the pipelined MIPS core, with MMIO
// cycle counter, tohost halt register, scratch register and an imem loader.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        err_misalign,
  output logic        err_unmapped
);

  localparam int unsigned IAW        = $clog2(IMEM_WORDS);
  localparam int unsigned DAW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] halt_code_q, halt_code_d;
  logic        halt_q, halt_d;
  logic        misalign_q, misalign_d;
  logic        unmapped_q, unmapped_d;

  // Instruction side: loader writes, core fetches.
  logic        fetch_ok_c;
  logic        ld_ok_c;
  logic [31:0] imem_rdata_c;

  assign fetch_ok_c = (pc < IMEM_BYTES) && (pc[1:0] == 2'b00);
  assign ld_ok_c    = ld_we && (ld_addr < IMEM_BYTES) && (ld_addr[1:0] == 2'b00);

  ram_1w1r_async #(.DEPTH(IMEM_WORDS)) u_imem (
    .clk_i  (clk),
    .we_i   (ld_ok_c),
    .waddr_i(ld_addr[IAW+1:2]),
    .wdata_i(ld_data),
    .raddr_i(pc[IAW+1:2]),
    .rdata_o(imem_rdata_c)
  );

  assign instr = fetch_ok_c ? imem_rdata_c : 32'h0;

  // Data side decode.
  region_e     region_c;
  logic [15:0] mmio_off_c;
  logic [31:0] dmem_rdata_c;
  logic        st_c;
  logic        st_aligned_c;
  logic        misalign_c;
  logic        dmem_we_c;
  logic        tohost_we_c;
  logic        scratch_we_c;
  logic        unmapped_c;

  assign region_c     = decode_region(aluout, DMEM_BYTES, MMIO_BASE);
  assign mmio_off_c   = {aluout[15:2], 2'b00};
  assign st_c         = memwrite && !rst;
  assign st_aligned_c = st_c && (aluout[1:0] == 2'b00);
  assign misalign_c   = st_c && (aluout[1:0] != 2'b00);
  assign dmem_we_c    = st_aligned_c && (region_c == REG_DMEM);
  assign tohost_we_c  = st_aligned_c && (region_c == REG_MMIO) && (aluout[15:0] == OFF_TOHOST);
  assign scratch_we_c = st_aligned_c && (region_c == REG_MMIO) && (aluout[15:0] == OFF_SCRATCH);
  assign unmapped_c   = st_aligned_c && !(dmem_we_c || tohost_we_c || scratch_we_c);

  ram_1w1r_async #(.DEPTH(DMEM_WORDS)) u_dmem (
    .clk_i  (clk),
    .we_i   (dmem_we_c),
    .waddr_i(aluout[DAW+1:2]),
    .wdata_i(writedata),
    .raddr_i(aluout[DAW+1:2]),
    .rdata_o(dmem_rdata_c)
  );

  // Load path ignores the byte offset and memwrite.
  always_comb begin
    readdata = 32'h0;
    case (region_c)
      REG_DMEM: readdata = dmem_rdata_c;
      REG_MMIO: begin
        if (mmio_off_c == OFF_CYCLE) begin
          readdata = cycle_q;
        end else if (mmio_off_c == OFF_SCRATCH) begin
          readdata = scratch_q;
        end
      end
      default: readdata = 32'h0;
    endcase
  end

  // MMIO register and sticky-flag next state.
  always_comb begin
    cycle_d     = halt_q ? cycle_q : cycle_q + 32'd1;
    scratch_d   = scratch_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    misalign_d  = misalign_q | misalign_c;
    unmapped_d  = unmapped_q | unmapped_c;
    if (tohost_we_c && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = writedata;
    end
    if (scratch_we_c) begin
      scratch_d = writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q     <= 32'h0;
      scratch_q   <= 32'h0;
      halt_q      <= 1'b0;
      halt_code_q <= 32'h0;
      misalign_q  <= 1'b0;
      unmapped_q  <= 1'b0;
    end else begin
      cycle_q     <= cycle_d;
      scratch_q   <= scratch_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      misalign_q  <= misalign_d;
      unmapped_q  <= unmapped_d;
    end
  end

  assign halt         = halt_q;
  assign halt_code    = halt_code_q;
  assign err_misalign = misalign_q;
  assign err_unmapped = unmapped_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: directed scenarios then random traffic
// against a word-level reference model of the memory map.
module tb_mips_mem_responder;

  localparam int unsigned IW    = 256;
  localparam int unsigned DW    = 256;
  localparam logic [31:0] MB    = 32'hFFFF_0000;
  localparam logic [15:0] MB_HI = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] instr;
  logic        memwrite = 1'b0;
  logic [31:0] aluout = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        ld_we = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic [31:0] ld_data = 32'h0;
  logic        halt;
  logic [31:0] halt_code;
  logic        err_misalign;
  logic        err_unmapped;

  always #5 clk = ~clk;

  mips_mem_responder dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr),
    .memwrite(memwrite), .aluout(aluout), .writedata(writedata), .readdata(readdata),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .halt(halt), .halt_code(halt_code),
    .err_misalign(err_misalign), .err_unmapped(err_unmapped)
  );

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [31:0] rd;
    bit          ci;
    bit          cr;
    logic        halt;
    logic [31:0] code;
    logic        mis;
    logic        unm;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (value after the most recent modelled edge).
  logic [31:0] imem_m [int];
  logic [31:0] dmem_m [int];
  logic [31:0] cyc_m = 0, scr_m = 0, code_m = 0;
  bit          halt_m = 0, mis_m = 0, unm_m = 0, known_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t predict(input string tag);
    exp_t e;
    e.tag = tag;
    e.ci = 1; e.cr = 1;
    e.instr = 32'h0; e.rd = 32'h0;
    if (pc < IW * 4 && pc % 4 == 0) begin
      if (imem_m.exists(int'(pc / 4))) e.instr = imem_m[int'(pc / 4)];
      else e.ci = 0;
    end
    if (aluout < DW * 4) begin
      if (dmem_m.exists(int'(aluout / 4))) e.rd = dmem_m[int'(aluout / 4)];
      else e.cr = 0;
    end else if (aluout[31:16] == MB_HI) begin
      if (aluout[15:0] / 4 == 0) e.rd = cyc_m;
      else if (aluout[15:0] / 4 == 2) e.rd = scr_m;
    end
    e.halt = halt_m; e.code = code_m; e.mis = mis_m; e.unm = unm_m;
    return e;
  endfunction

  // Apply the effect of the coming rising edge to the model.
  task automatic model_edge();
    bit was_halted;
    if (ld_we && ld_addr < IW * 4 && ld_addr % 4 == 0) imem_m[int'(ld_addr / 4)] = ld_data;
    if (rst) begin
      known_m = 1; halt_m = 0; code_m = 0; mis_m = 0; unm_m = 0; cyc_m = 0; scr_m = 0;
    end else begin
      was_halted = halt_m;
      if (memwrite) begin
        if (aluout % 4 != 0) mis_m = 1;
        else if (aluout < DW * 4) dmem_m[int'(aluout / 4)] = writedata;
        else if (aluout == MB + 32'd4) begin
          if (!halt_m) begin halt_m = 1; code_m = writedata; end
        end else if (aluout == MB + 32'd8) scr_m = writedata;
        else unm_m = 1;
      end
      if (!was_halted) cyc_m = cyc_m + 32'd1;
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [31:0] p,
                      input logic mw, input logic [31:0] a, input logic [31:0] wd,
                      input logic lwe = 1'b0, input logic [31:0] la = 32'h0,
                      input logic [31:0] ldd = 32'h0);
    @(negedge clk);
    rst = r; pc = p; memwrite = mw; aluout = a; writedata = wd;
    ld_we = lwe; ld_addr = la; ld_data = ldd;
    if (known_m) sbq.push_back(predict(tag));
    model_edge();
  endtask

  // Preset the cycle counter near its wrap point for one idle cycle.
  task automatic wrap_backdoor();
    @(negedge clk);
    rst = 1'b0; memwrite = 1'b0; ld_we = 1'b0;
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    cyc_m = 32'hFFFF_FFFE;
    model_edge();
  endtask

  // Monitor: compare every presented cycle against its queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.ci) chk({e.tag, ".instr"}, instr, e.instr);
        if (e.cr) chk({e.tag, ".readdata"}, readdata, e.rd);
        chk({e.tag, ".halt"}, 32'(halt), 32'(e.halt));
        chk({e.tag, ".halt_code"}, halt_code, e.code);
        chk({e.tag, ".err_misalign"}, 32'(err_misalign), 32'(e.mis));
        chk({e.tag, ".err_unmapped"}, 32'(err_unmapped), 32'(e.unm));
      end
    end
  end

  initial begin
    logic [31:0] p, a, la;
    logic        mw, lwe;
    int          sel;

    // Load imem during reset.
    step("rst_ld0", 1, 0, 0, 0, 0, 1, 32'h0,  32'h2402_0001);
    step("rst_ld1", 1, 0, 0, 0, 0, 1, 32'h4,  32'h2403_0002);
    step("rst_ld2", 1, 0, 0, 0, 0, 1, 32'h8,  32'h0043_2020);
    step("rst_ld3", 1, 0, 0, 0, 0, 1, 32'hC,  32'hAC04_0010);
    step("rst_chk", 1, 0, 0, 0, 0);

    // Fetch boundaries and loader corner cases.
    step("fetch_w2",   0, 32'h8,   0, 0, 0, 1, 32'h3FC, 32'hCAFE_F00D);
    step("fetch_oob",  0, 32'h402, 0, 0, 0);
    step("fetch_400",  0, 32'h400, 0, 0, 0);
    step("fetch_last", 0, 32'h3FC, 0, 0, 0);
    step("fetch_mis",  0, 32'h9,   0, 0, 0, 1, 32'h9, 32'h1234_5678);
    step("ld_same",    0, 32'h8,   0, 0, 0, 1, 32'h8, 32'h0BAD_0BAD);
    step("ld_after",   0, 32'h8,   0, 0, 0, 1, 32'h400, 32'h5555_5555);
    step("fetch_w1",   0, 32'h4,   0, 0, 0);

    // Data RAM store, read-during-write, byte-offset read.
    step("st_old", 0, 0, 1, 32'h10, 32'h1111_1111);
    step("st_new", 0, 0, 1, 32'h10, 32'hDEAD_BEEF);
    step("rd_13",  0, 0, 0, 32'h13, 0);
    step("rd_10",  0, 0, 0, 32'h10, 0);

    // Error stores.
    step("st_mis",   0, 0, 1, 32'h11, 32'h0);
    step("rd_after", 0, 0, 0, 32'h10, 0);
    step("st_unm",   0, 0, 1, 32'h8000_0000, 32'h1);
    step("st_cnt",   0, 0, 1, MB, 32'h1);
    step("st_end",   0, 0, 1, 32'h400, 32'h1);
    step("flags",    0, 0, 0, 32'h10, 0);

    // Counter after reset, then halt.
    step("rst_cnt", 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("cnt_run", 0, 0, 0, MB, 0);
    step("cnt_10",   0, 0, 0, MB, 0);
    step("tohost1",  0, 0, 1, MB + 32'd4, 32'h1);
    step("tohost2",  0, 0, 1, MB + 32'd4, 32'h2);
    for (int i = 0; i < 3; i++) step("frozen", 0, 0, 0, MB, 0);

    // Scratch and reset retention.
    step("scr_wr",  0, 0, 1, MB + 32'd8, 32'h5A5A);
    step("scr_rd",  0, 0, 0, MB + 32'd9, 0);
    step("tohost_rd", 0, 0, 0, MB + 32'd4, 0);
    step("mmio_c",  0, 0, 0, MB + 32'hC, 0);
    step("rst_pulse", 1, 0, 1, 32'h20, 32'h7777_7777);
    step("scr_clr", 0, 0, 0, MB + 32'd8, 0);
    step("ram_keep", 0, 0, 0, 32'h10, 0);

    // Counter wrap.
    wrap_backdoor();
    for (int i = 0; i < 3; i++) step("wrap", 0, 0, 0, MB, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel < 2) p = 32'($urandom_range(0, 15)) * 4;
      else if (sel == 2) p = 32'($urandom_range(0, 32'h500));
      else p = $urandom;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: a = 32'($urandom_range(0, 15)) * 4;
        1: a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        2: a = MB + 32'($urandom_range(0, 15));
        3: a = $urandom;
        4: a = MB + 32'd4;
        default: a = 32'h400 + 32'($urandom_range(0, 7));
      endcase
      mw = ($urandom_range(0, 2) == 0);
      if (sel == 4 && $urandom_range(0, 3) != 0) mw = 1'b0;
      lwe = ($urandom_range(0, 3) == 0);
      la = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) * 4
                                       : 32'($urandom_range(0, IW * 4 + 16));
      step("rand", ($urandom_range(0, 39) == 0), p, mw, a, $urandom, lwe, la, $urandom);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
